aes_enc_sequencer: RTL

- Host-side control stage directly upstream of the AES-128 encryption core, and the consumer of its result.
- Assembles a 128-bit key and plaintext from 32-bit host writes, then drives the core's Krdy/Drdy/EN handshake.
- Waits for core completion, captures the ciphertext and streams it back as four 32-bit words with valid/ready.
- Measures encryption latency in cycles for the ring-oscillator sensor experiments.

---
 rtl/aes_seq_pkg.sv | 24 ++
 rtl/aes_seq_serializer.sv | 47 ++++
 rtl/aes_enc_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES-128 encryption sequencer.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY_LOAD,
        KEY_WAIT,
        DATA_LOAD,
        ENC_WAIT,
        OUT,
        ERR_ABORT
    } state_e;

    localparam logic [2:0] ADDR_KEY0  = 3'd0;
    localparam logic [2:0] ADDR_DATA0 = 3'd4;
    localparam int         WORD_CNT   = 4;
    localparam int         WORD_W     = 32;

    // Packed slot of a host word: word 0 of a block is its most significant 32 bits.
    function automatic logic [1:0] word_slot(input logic [2:0] addr, input logic [2:0] base);
        return 2'(WORD_CNT - 1) - 2'(addr - base);
    endfunction

endpackage

// File: rtl/aes_seq_serializer.sv
// 128-to-32 bit valid/ready serializer: most significant word first, done on last accept.
module aes_seq_serializer
    import aes_seq_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       load_i,
    input  logic [WORD_CNT*WORD_W-1:0] data_i,
    output logic [WORD_W-1:0]          data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       done_o
);

    logic [WORD_CNT*WORD_W-1:0] shift_q;
    logic [1:0]                 idx_q;
    logic                       valid_q;
    logic                       accept;

    assign accept  = valid_q && ready_i;
    assign done_o  = accept && (idx_q == 2'(WORD_CNT - 1));
    assign data_o  = shift_q[WORD_CNT*WORD_W-1 -: WORD_W];
    assign valid_o = valid_q;

    // Capture a block on load, shift one word out per accepted handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the result register is reset too so out_data reads zero after reset,
            // and a partially streamed block is discarded rather than resumed.
            shift_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            shift_q <= data_i;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (accept) begin
            shift_q <= {shift_q[(WORD_CNT-1)*WORD_W-1:0], {WORD_W{1'b0}}};
            idx_q   <= idx_q + 2'd1;
            if (done_o) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aes_enc_sequencer.sv
// Host-side sequencer for the AES-128 core: word-assembled key/data, Krdy/Drdy/EN
// handshake, ciphertext streaming and encryption latency measurement.
module aes_enc_sequencer
    import aes_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int LAT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             cmd_key,
    input  logic             cmd_enc,
    output logic             busy,
    output logic             err,
    output logic [LAT_W-1:0] lat_cycles,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     aes_kin,
    output logic [127:0]     aes_din,
    output logic             aes_krdy,
    output logic             aes_drdy,
    output logic             aes_en,
    input  logic [127:0]     aes_dout,
    input  logic             aes_bsy,
    input  logic             aes_kvld,
    input  logic             aes_dvld
);

    logic [WORD_CNT-1:0][WORD_W-1:0] key_q;
    logic [WORD_CNT-1:0][WORD_W-1:0] data_q;

    state_e           state_q;
    logic             key_loaded_q;
    logic             pend_enc_q;
    logic             err_q;
    logic             krdy_q;
    logic             drdy_q;
    logic             en_q;
    logic [LAT_W-1:0] wait_cnt_q;
    logic [LAT_W-1:0] wait_inc_d;
    logic [LAT_W-1:0] lat_q;
    logic             wait_expired;
    logic             enc_done;
    logic             ser_done;

    // One counter serves both the key-wait timeout and the encryption latency.
    assign wait_inc_d   = (wait_cnt_q == {LAT_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + 1'b1;
    assign wait_expired = (wait_inc_d >= LAT_W'(TIMEOUT_CYC));
    assign enc_done     = (state_q == ENC_WAIT) && !aes_bsy && aes_dvld;

    assign busy       = (state_q != IDLE);
    assign err        = err_q;
    assign lat_cycles = lat_q;
    assign aes_kin    = key_q;
    assign aes_din    = data_q;
    assign aes_krdy   = krdy_q;
    assign aes_drdy   = drdy_q;
    assign aes_en     = en_q;

    // Host word writes, accepted only while idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            key_q  <= '0;
            data_q <= '0;
        end else if (wr_en && (state_q == IDLE)) begin
            if (wr_addr >= ADDR_DATA0) begin
                data_q[word_slot(wr_addr, ADDR_DATA0)] <= wr_data;
            end else begin
                key_q[word_slot(wr_addr, ADDR_KEY0)] <= wr_data;
            end
        end
    end

    // Command FSM with registered core handshake, error and latency outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            key_loaded_q <= 1'b0;
            pend_enc_q   <= 1'b0;
            err_q        <= 1'b0;
            krdy_q       <= 1'b0;
            drdy_q       <= 1'b0;
            en_q         <= 1'b0;
            wait_cnt_q   <= '0;
            lat_q        <= '0;
        end else begin
            krdy_q <= 1'b0;
            drdy_q <= 1'b0;
            en_q   <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (cmd_key) begin
                        state_q    <= KEY_LOAD;
                        krdy_q     <= 1'b1;
                        pend_enc_q <= cmd_enc;
                        err_q      <= 1'b0;
                    end else if (cmd_enc) begin
                        if (key_loaded_q) begin
                            state_q <= DATA_LOAD;
                            err_q   <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                KEY_LOAD: begin
                    state_q    <= KEY_WAIT;
                    wait_cnt_q <= '0;
                end
                KEY_WAIT: begin
                    wait_cnt_q <= wait_inc_d;
                    if (aes_kvld) begin
                        key_loaded_q <= 1'b1;
                        pend_enc_q   <= 1'b0;
                        state_q      <= pend_enc_q ? DATA_LOAD : IDLE;
                    end else if (wait_expired) begin
                        state_q      <= ERR_ABORT;
                        err_q        <= 1'b1;
                        en_q         <= 1'b0;
                        pend_enc_q   <= 1'b0;
                        key_loaded_q <= 1'b0;
                    end
                end
                DATA_LOAD: begin
                    if (!aes_bsy) begin
                        state_q    <= ENC_WAIT;
                        drdy_q     <= 1'b1;
                        wait_cnt_q <= '0;
                    end
                end
                ENC_WAIT: begin
                    wait_cnt_q <= wait_inc_d;
                    if (enc_done) begin
                        state_q <= OUT;
                        lat_q   <= wait_inc_d;
                    end else if (wait_expired) begin
                        state_q    <= ERR_ABORT;
                        err_q      <= 1'b1;
                        en_q       <= 1'b0;
                        pend_enc_q <= 1'b0;
                    end
                end
                OUT: begin
                    if (ser_done) begin
                        state_q <= IDLE;
                    end
                end
                ERR_ABORT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    aes_seq_serializer u_serializer (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (enc_done),
        .data_i  (aes_dout),
        .data_o  (out_data),
        .valid_o (out_valid),
        .ready_i (out_ready),
        .done_o  (ser_done)
    );

endmodule
